// File: rtl/demux_serial_dispatcher.sv
// demux_serial_dispatcher
// Upstream feeder for the hierarchical 1:4 demux. Accepts a parallel word and a
// 2-bit destination over a valid/ready handshake. Shifts the word out MSB-first
// on D while S holds the destination and En stays high. Afterwards it keeps En
// low for GAP_CYCLES cycles so that downstream receivers can see frame boundaries.
// Optional build macro: DISPATCH_PARITY_EN appends one even-parity bit to every
// frame. When set, frame_done moves onto that parity bit.
module demux_serial_dispatcher #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  output logic              D,
  output logic [1:0]        S,
  output logic              En,
  output logic              busy,
  output logic              frame_done
);

  // Bit counter counts down from DATA_W-1 to 0 across the data bits of a frame.
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // The gap counter counts down from GAP_CYCLES-1. When there is no gap,
  // its load value is unused because the FSM never enters GAP.
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  // Reject illegal configurations at elaboration time.
  generate
    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
      $error("demux_serial_dispatcher: DATA_W must be within 2..32");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
      $error("demux_serial_dispatcher: GAP_CYCLES must be within 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [3:0]        gap_reg;
`ifdef DISPATCH_PARITY_EN
  logic              parity_reg;     // even parity of the captured word
  logic              par_phase_reg;  // high while the parity bit is on D
`endif

  // Only IDLE accepts a word. Reset forces the handshake closed right away,
  // without waiting for an edge.
  assign in_ready = (state_reg == IDLE) && rst_n;
  assign busy     = (state_reg != IDLE);

  // Frame sequencer. D, S, En and frame_done are all registered so that the
  // demux sees clean, glitch-free controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      gap_reg       <= '0;
      D             <= 1'b0;
      S             <= 2'b00;
      En            <= 1'b0;
      frame_done    <= 1'b0;
`ifdef DISPATCH_PARITY_EN
      parity_reg    <= 1'b0;
      par_phase_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          D          <= 1'b0;
          En         <= 1'b0;
          frame_done <= 1'b0;
          // in_ready is implied here: the state is IDLE and rst_n is high.
          if (in_valid) begin
            shift_reg <= in_data;
            S         <= in_dest;
            D         <= in_data[DATA_W-1];
            En        <= 1'b1;
            cnt_reg   <= CNT_LOAD;
            state_reg <= SHIFT;
`ifdef DISPATCH_PARITY_EN
            parity_reg    <= ^in_data;
            par_phase_reg <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          if (cnt_reg != CNT_ZERO) begin
            // Present the next lower bit. The shift register's MSB always
            // mirrors the bit currently on D.
            shift_reg <= shift_reg << 1;
            D         <= shift_reg[DATA_W-2];
            cnt_reg   <= cnt_reg - CNT_ONE;
`ifdef DISPATCH_PARITY_EN
            frame_done <= 1'b0;
`else
            frame_done <= (cnt_reg == CNT_ONE);
`endif
          end else begin
`ifdef DISPATCH_PARITY_EN
            if (!par_phase_reg) begin
              // One extra En-high cycle that carries the parity bit.
              D             <= parity_reg;
              frame_done    <= 1'b1;
              par_phase_reg <= 1'b1;
            end else begin
`else
            begin
`endif
              // The frame is complete. Drop En and then either idle for the
              // gap or reopen the handshake immediately.
              D          <= 1'b0;
              En         <= 1'b0;
              frame_done <= 1'b0;
              gap_reg    <= GAP_LOAD;
              state_reg  <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end
          end
        end

        GAP: begin
          D          <= 1'b0;
          En         <= 1'b0;
          frame_done <= 1'b0;
          if (gap_reg == 4'd0) begin
            state_reg <= IDLE;
          end else begin
            gap_reg <= gap_reg - 4'd1;
          end
        end

        default: begin
          state_reg  <= IDLE;
          D          <= 1'b0;
          En         <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_serial_dispatcher.sv
// tb_demux_serial_dispatcher
// Self-checking bench for demux_serial_dispatcher. A queue-based reference model
// turns each accepted word into the list of per-cycle (D, S, En, frame_done)
// beats that should follow it. Directed scenario tasks and a randomized task
// compare the DUT against that list on every falling edge.
// Honours DISPATCH_PARITY_EN in the same way as the design.
module tb_demux_serial_dispatcher;

  localparam int DATA_W     = 8;
  localparam int GAP_CYCLES = 1;
`ifdef DISPATCH_PARITY_EN
  localparam bit PARITY    = 1'b1;
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam bit PARITY    = 1'b0;
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int PERIOD = FRAME_LEN + GAP_CYCLES + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [1:0]        in_dest = 2'b00;
  logic              in_ready;
  logic              D;
  logic [1:0]        S;
  logic              En;
  logic              busy;
  logic              frame_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  demux_serial_dispatcher #(
    .DATA_W    (DATA_W),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .D         (D),
    .S         (S),
    .En        (En),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       d;
    logic [1:0] s;
    logic       en;
    logic       fd;
  } beat_t;

  beat_t      pend_q[$];
  beat_t      cur = '0;
  beat_t      mb;
  logic       cur_idle = 1'b1;
  logic [1:0] last_s = 2'b00;

  task model_edge();
    if (!rst_n) begin
      pend_q.delete();
      cur      = '0;
      cur_idle = 1'b1;
      last_s   = 2'b00;
    end else begin
      if (cur_idle && in_valid) begin
        for (int i = DATA_W - 1; i >= 0; i--) begin
          mb.d  = in_data[i];
          mb.s  = in_dest;
          mb.en = 1'b1;
          mb.fd = (i == 0) && !PARITY;
          pend_q.push_back(mb);
        end
        if (PARITY) begin
          mb.d  = ^in_data;
          mb.s  = in_dest;
          mb.en = 1'b1;
          mb.fd = 1'b1;
          pend_q.push_back(mb);
        end
        for (int g = 0; g < GAP_CYCLES; g++) begin
          mb = '0;
          mb.s = in_dest;
          pend_q.push_back(mb);
        end
        last_s = in_dest;
      end
      if (pend_q.size() > 0) begin
        cur      = pend_q.pop_front();
        cur_idle = 1'b0;
      end else begin
        cur      = '0;
        cur.s    = last_s;
        cur_idle = 1'b1;
      end
    end
  endtask

  always @(posedge clk) model_edge();

  function automatic logic [6:0] expv();
    return {cur.d, cur.s, cur.en, cur.fd, cur_idle & rst_n, ~cur_idle};
  endfunction

  function automatic logic [6:0] obsv();
    return {D, S, En, frame_done, in_ready, busy};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL reset_model cyc%0d: got %b expected %b", k, obsv(), expv());
      end
      vectors++;
      if (obsv() !== 7'b0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc%0d: got %b expected %b", k, obsv(), 7'b0);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (obsv() !== 7'b0_00_0_0_1_0) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected %b", obsv(), 7'b0_00_0_0_1_0);
    end
    $display("test_reset: 3 cycles in reset, released");
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] got;
    int fd_cnt;
    int fd_at;
    got = '0;
    fd_cnt = 0;
    fd_at = -1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    in_dest = 2'd2;
    for (int k = 1; k <= PERIOD + 1; k++) begin
      @(negedge clk);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL single_model k%0d: got %b expected %b", k, obsv(), expv());
      end
      if (k == 1) begin
        in_valid = 1'b0;
        vectors++;
        if (S !== 2'd2) begin
          miscompares++;
          $display("FAIL single_s: got %0d expected 2", S);
        end
      end
      if (En && k <= DATA_W) got = {got[DATA_W-2:0], D};
      if (frame_done) begin
        fd_cnt++;
        fd_at = k;
      end
      if (k == FRAME_LEN + 1) begin
        vectors++;
        if (En !== 1'b0) begin
          miscompares++;
          $display("FAIL single_en_low: got %b expected 0", En);
        end
      end
      if (k == PERIOD - 1) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL single_ready_early: got %b expected 0", in_ready);
        end
      end
      if (k == PERIOD) begin
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL single_ready_back: got %b expected 1", in_ready);
        end
      end
    end
    vectors++;
    if (got !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_bits: got %h expected a5", got);
    end
    vectors++;
    if (fd_cnt != 1 || fd_at != FRAME_LEN) begin
      miscompares++;
      $display("FAIL single_frame_done: got count %0d at %0d expected count 1 at %0d", fd_cnt, fd_at, FRAME_LEN);
    end
    $display("test_single: sent a5 to dest 2, received %h", got);
  endtask

  task automatic test_back_to_back();
    int rise[2];
    int nr;
    logic prev_en;
    logic [1:0] prev_s;
    bit drop;
    nr = 0;
    drop = 1'b0;
    rise[0] = -1;
    rise[1] = -1;
    prev_en = En;
    prev_s = S;
    in_valid = 1'b1;
    in_data = 8'hFF;
    in_dest = 2'd0;
    for (int k = 1; k <= 2 * PERIOD + 1; k++) begin
      @(negedge clk);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL b2b_model k%0d: got %b expected %b", k, obsv(), expv());
      end
      if (En && !prev_en && nr < 2) begin
        rise[nr] = k;
        nr++;
      end
      vectors++;
      if (S !== prev_s && prev_en) begin
        miscompares++;
        $display("FAIL b2b_s_stable k%0d: S went %0d -> %0d expected no change while En=1", k, prev_s, S);
      end
      prev_s = S;
      prev_en = En;
      if (k == 1) begin
        in_data = 8'h00;
        in_dest = 2'd3;
      end else if (drop) begin
        in_valid = 1'b0;
      end else if (in_ready && in_valid) begin
        drop = 1'b1;
      end
    end
    vectors++;
    if (nr != 2 || (rise[1] - rise[0]) != PERIOD) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d rises spaced %0d expected 2 spaced %0d", nr, rise[1] - rise[0], PERIOD);
    end
    $display("test_back_to_back: ff->dest0, 00->dest3, En rises at %0d and %0d", rise[0], rise[1]);
  endtask

  task automatic test_held_source();
    logic [DATA_W-1:0] w[2];
    int en_cnt;
    int first2;
    w[0] = '0;
    w[1] = '0;
    en_cnt = 0;
    first2 = -1;
    in_valid = 1'b1;
    in_data = 8'h3C;
    in_dest = 2'd1;
    for (int k = 1; k <= 2 * PERIOD + 1; k++) begin
      @(negedge clk);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL held_model k%0d: got %b expected %b", k, obsv(), expv());
      end
      if (En) begin
        if (en_cnt == FRAME_LEN) first2 = k;
        if ((en_cnt % FRAME_LEN) < DATA_W && en_cnt < 2 * FRAME_LEN)
          w[en_cnt / FRAME_LEN] = {w[en_cnt / FRAME_LEN][DATA_W-2:0], D};
        en_cnt++;
      end
      if (k == 1) in_data = 8'h5A;
      if (k == 3) begin
        in_data = 8'hC3;
        in_dest = 2'd0;
      end
      if (k == PERIOD + 1) in_valid = 1'b0;
    end
    vectors++;
    if (w[0] !== 8'h3C) begin
      miscompares++;
      $display("FAIL held_first_word: got %h expected 3c", w[0]);
    end
    vectors++;
    if (w[1] !== 8'hC3) begin
      miscompares++;
      $display("FAIL held_second_word: got %h expected c3", w[1]);
    end
    vectors++;
    if (first2 != PERIOD + 1) begin
      miscompares++;
      $display("FAIL held_second_start: got cycle %0d expected %0d", first2, PERIOD + 1);
    end
    $display("test_held_source: frames %h then %h", w[0], w[1]);
  endtask

  task automatic test_mid_reset();
    int en_cnt;
    int fd_seen;
    en_cnt = 0;
    fd_seen = 0;
    in_valid = 1'b1;
    in_data = 8'h81;
    in_dest = 2'd1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL midrst_model k%0d: got %b expected %b", k, obsv(), expv());
      end
      if (k == 1) in_valid = 1'b0;
      if (frame_done) fd_seen++;
      if (En) en_cnt++;
      if (k == 4) rst_n = 1'b0;
      if (k == 5) begin
        vectors++;
        if ({En, D} !== 2'b00) begin
          miscompares++;
          $display("FAIL midrst_abandon: got En,D=%b expected 00", {En, D});
        end
        rst_n = 1'b1;
      end
      if (k == 6) begin
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL midrst_ready: got %b expected 1", in_ready);
        end
      end
    end
    vectors++;
    if (en_cnt != 4 || fd_seen != 0) begin
      miscompares++;
      $display("FAIL midrst_counts: got %0d En cycles, %0d frame_done expected 4, 0", en_cnt, fd_seen);
    end
    $display("test_mid_reset: 81 abandoned after %0d bits", en_cnt);
  endtask

`ifdef DISPATCH_PARITY_EN
  task automatic test_parity();
    int en_cnt;
    int fd_at;
    logic par_bit;
    en_cnt = 0;
    fd_at = -1;
    par_bit = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h07;
    in_dest = 2'd3;
    for (int k = 1; k <= PERIOD + 1; k++) begin
      @(negedge clk);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL parity_model k%0d: got %b expected %b", k, obsv(), expv());
      end
      if (k == 1) in_valid = 1'b0;
      if (En) begin
        en_cnt++;
        if (en_cnt == DATA_W + 1) par_bit = D;
        if (frame_done) fd_at = en_cnt;
      end
    end
    vectors++;
    if (en_cnt != 9 || par_bit !== 1'b1 || fd_at != 9) begin
      miscompares++;
      $display("FAIL parity_frame: got len %0d parity %b done@%0d expected 9, 1, 9", en_cnt, par_bit, fd_at);
    end
    $display("test_parity: 07 sent, parity bit %b", par_bit);
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL random_model k%0d: got %b expected %b", k, obsv(), expv());
      end
      if (in_valid && in_ready)
        $display("random: accept data %h dest %0d at step %0d", in_data, in_dest, k);
      rst_n = ($urandom_range(0, 99) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data = DATA_W'($urandom);
      in_dest = 2'($urandom);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k <= PERIOD; k++) begin
      @(negedge clk);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL random_drain k%0d: got %b expected %b", k, obsv(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_held_source();
    test_mid_reset();
`ifdef DISPATCH_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_serial_dispatcher.md
Name: demux_serial_dispatcher

Overview:
- Upstream feeder for the hierarchical 1:4 demux.
- Accepts a parallel word plus a 2-bit destination over a valid/ready handshake.
- Serializes the word MSB-first onto the demux D input, holding S at the destination and En high for the whole frame.
- Inserts a programmable idle gap between frames so downstream channel receivers can see frame boundaries.

Parameters:
DATA_W, 8, payload width in bits (legal range 2..32)
GAP_CYCLES, 1, idle cycles with En low between frames (legal range 0..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  source has a word to send
in_ready  output  1  dispatcher can accept a word this cycle
in_data  input  DATA_W  payload word
in_dest  input  2  destination channel 0..3
D  output  1  serial data bit to demux D
S  output  2  channel select to demux S
En  output  1  enable to demux En
busy  output  1  frame or gap in progress
frame_done  output  1  one-cycle pulse, coincident with the last bit of a frame

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low. All state updates on the rising edge of clk.
- Reset (rst_n low at an edge):
  - state=IDLE, D=0, S=2'b00, En=0, frame_done=0, bit counter=0, gap counter=0.
  - in_ready is held 0 while rst_n is low.
  - busy=0.
- Registered outputs: D, S, En and frame_done are registered. in_ready = (state==IDLE) && rst_n. busy = (state!=IDLE).
- States: IDLE, SHIFT, GAP.
- IDLE:
  - En=0, D=0. S holds its last value.
  - On in_valid && in_ready: capture in_data into the shift register and in_dest into the select register, load the bit counter with DATA_W-1, go to SHIFT.
  - At the same edge, S takes in_dest, D takes in_data[DATA_W-1], and En goes to 1.
  - The first bit is therefore visible the cycle after acceptance (latency 1).
- SHIFT:
  - Each edge: shift left, D takes the next bit, decrement the counter. En=1, S stable.
  - The last bit is driven together with frame_done=1 for exactly one cycle.
  - At the edge after the last bit, En=0 and D=0:
    - GAP_CYCLES>0: go to GAP with gap counter = GAP_CYCLES-1.
    - GAP_CYCLES==0: go to IDLE.
  - Frame length: DATA_W cycles with En=1.
- GAP:
  - En=0, D=0, S held.
  - Decrement the gap counter. When it reaches 0, go to IDLE at the next edge.
  - GAP lasts exactly GAP_CYCLES cycles.
- Handshake:
  - in_valid while in_ready=0 is ignored. The source must hold in_data and in_dest until it sees in_ready.
  - in_data and in_dest are sampled only at the accept edge. Later changes do not affect the frame in flight.
- Throughput: one frame per DATA_W + GAP_CYCLES + 1 cycles, including the IDLE accept cycle.
- Reset mid-frame: the frame is abandoned. En=0 and D=0 from the next edge, and frame_done is not pulsed.
- Out-of-range parameters: elaboration error via generate-time check.

Optional Feature:
- Macro DISPATCH_PARITY_EN.
- When defined:
  - After the last data bit, one extra cycle drives D = even parity (XOR of all DATA_W captured bits) with En=1 and S held.
  - frame_done moves to coincide with the parity bit.
  - Frame length becomes DATA_W+1.
- When undefined:
  - No parity cycle, and frame length is DATA_W as above.
  - No parity logic is synthesized.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, then release -> D=0, S=0, En=0, frame_done=0, in_ready=0 during reset and 1 the cycle after release.
- Single frame: in_data=8'hA5, in_dest=2 accepted at cycle t -> cycles t+1..t+8 show D=1,0,1,0,0,1,0,1 with S=2, En=1. frame_done=1 only at t+8. En=0 at t+9. in_ready=1 again at t+10 (GAP_CYCLES=1).
- Back-to-back: in_valid held high with dest 0 (8'hFF) then dest 3 (8'h00) -> second frame En rises exactly DATA_W+GAP_CYCLES+1=10 cycles after the first. S changes only while En=0.
- Held source while busy: change in_data from 8'h3C to 8'hC3 during SHIFT -> serialized bits remain 8'h3C. The second word is accepted only when in_ready=1.
- Reset mid-frame: assert rst_n=0 after 4 bits of 8'h81 -> En=0 and D=0 at the next edge, no frame_done, in_ready=1 after release.
- DISPATCH_PARITY_EN defined: send 8'h07 -> 8 data bits then parity bit D=1, 9 cycles with En=1, frame_done on the 9th.
